// File: rtl/bcd_stopwatch_if.sv
// Stopwatch pin bundle: raw buttons in, BCD display value and dots out.
// The master drives the buttons; the stopwatch is the slave.
interface bcd_stopwatch_if;
  logic        startStop;
  logic        clear;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        running;

  modport master (
    output startStop,
    output clear,
    input  value,
    input  dots,
    input  running
  );

  modport slave (
    input  startStop,
    input  clear,
    output value,
    output dots,
    output running
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// 000.0-999.9 s BCD stopwatch with debounced start/stop and clear buttons.
// Drives the 7-segment value/dots and saturates at 999.9 until cleared.
module bcd_stopwatch #(
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 50000
) (
  input logic           clock,
  input logic           reset,
  bcd_stopwatch_if.slave sw
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q, deb_prev_d;
  logic [1:0]    pulse_q, pulse_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   value_q, value_d;
  logic          ovf_q, ovf_d;
  logic          running_q, running_d;
  logic [3:0]    dots_q, dots_d;
  logic          ss, clr, tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // bit 0 = startStop, bit 1 = clear
  always_comb begin
    sync1_d = {sw.clear, sw.startStop};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_MAX) deb_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    deb_prev_d = deb_q;
    pulse_d    = deb_q & ~deb_prev_q;
  end

  always_comb begin
    ss      = pulse_q[0];
    clr     = pulse_q[1];
    tick    = (state_q == RUN) && (pre_q == PRE_MAX);
    state_d = state_q;
    pre_d   = pre_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (ss) state_d = RUN;
      end
      RUN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          if (value_q == 16'h9999) begin
            ovf_d   = 1'b1;
            state_d = STOP;
          end else begin
            value_d = bcd_inc(value_q);
          end
        end
        if (ss) state_d = STOP;
      end
      STOP: begin
        // clear wins over a simultaneous start/stop
        if (clr) begin
          state_d = IDLE;
          pre_d   = '0;
          value_d = '0;
          ovf_d   = 1'b0;
        end else if (ss && !ovf_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    dots_d    = {ovf_d, 1'b0, 1'b1, running_d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      cnt_q      <= '{default: '0};
      state_q    <= IDLE;
      pre_q      <= '0;
      value_q    <= '0;
      ovf_q      <= 1'b0;
      running_q  <= 1'b0;
      dots_q     <= 4'b0010;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      value_q    <= value_d;
      ovf_q      <= ovf_d;
      running_q  <= running_d;
      dots_q     <= dots_d;
    end
  end

  assign sw.value   = value_q;
  assign sw.dots    = dots_q;
  assign sw.running = running_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: directed and random button activity checked
// each cycle against a tenths-of-seconds reference model.
module tb_bcd_stopwatch;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bcd_stopwatch_if sw ();

  bcd_stopwatch #(
    .TICK_DIV(TD),
    .DEBOUNCE(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw   (sw)
  );

  always #5 clock = ~clock;

  // reference model: 0=idle 1=run 2=stop
  int m_edge = 0;
  int m_state = 0;
  int m_tenths = 0;
  int m_frac = 0;
  bit m_ovf = 0;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_deb [2];
  int m_run [2];
  int m_fire [2];

  function automatic logic [15:0] to_bcd(input int t);
    return {4'(t / 1000 % 10), 4'(t / 100 % 10),
            4'(t / 10 % 10), 4'(t % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ss, clr, tick, raw;
    m_edge++;
    if (reset) begin
      m_state = 0; m_tenths = 0; m_frac = 0; m_ovf = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0;
        m_run[b] = 0; m_fire[b] = -10;
      end
      return;
    end
    ss   = (m_fire[0] == m_edge);
    clr  = (m_fire[1] == m_edge);
    tick = (m_state == 1) && (m_frac == TD - 1);
    case (m_state)
      0: if (ss) m_state = 1;
      1: begin
        m_frac = (m_frac + 1) % TD;
        if (tick) begin
          if (m_tenths == 9999) begin
            m_ovf = 1; m_state = 2;
          end else begin
            m_tenths++;
          end
        end
        if (ss) m_state = 2;
      end
      default: begin
        if (clr) begin
          m_state = 0; m_tenths = 0; m_ovf = 0; m_frac = 0;
        end else if (ss && !m_ovf) begin
          m_state = 1;
        end
      end
    endcase
    for (int b = 0; b < 2; b++) begin
      raw = (b == 0) ? sw.startStop : sw.clear;
      if (m_s2[b] != m_deb[b]) m_run[b]++;
      else m_run[b] = 0;
      if (m_run[b] == DB) begin
        m_deb[b] = m_s2[b];
        m_run[b] = 0;
        if (m_deb[b]) m_fire[b] = m_edge + 2;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("value", sw.value, to_bcd(m_tenths));
    chk("running", {15'b0, sw.running}, {15'b0, m_state == 1});
    chk("dots", {12'b0, sw.dots},
        {12'b0, m_ovf, 1'b0, 1'b1, m_state == 1});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int b, input int hold);
    if (b == 0) sw.startStop = 1'b1;
    else sw.clear = 1'b1;
    steps(hold);
    sw.startStop = 1'b0;
    sw.clear = 1'b0;
  endtask

  task automatic wait_tenths(input int t, input int budget);
    int n;
    n = 0;
    while (m_tenths < t && !m_ovf && n < budget) begin
      step();
      n++;
    end
    chk("wait_bound", {15'b0, n < budget}, 16'h0001);
  endtask

  initial begin
    int n;
    int saved;
    sw.startStop = 1'b0;
    sw.clear = 1'b0;
    reset = 1'b1;
    steps(2);
    chk("rst_value", sw.value, 16'h0000);
    chk("rst_dots", {12'b0, sw.dots}, 16'h0002);
    chk("rst_running", {15'b0, sw.running}, 16'h0000);
    reset = 1'b0;
    steps(3);

    // first start: RUN 7 cycles after raw rise
    sw.startStop = 1'b1;
    steps(6);
    chk("start_c6", {15'b0, sw.running}, 16'h0000);
    steps(1);
    chk("start_c7", {15'b0, sw.running}, 16'h0001);
    steps(3);
    sw.startStop = 1'b0;
    steps(45);
    chk("run48_value", sw.value, 16'h0012);
    chk("run48_dots", {12'b0, sw.dots}, 16'h0003);

    press(0, 10);
    steps(5);
    press(1, 10);
    steps(5);
    chk("back_idle", sw.value, 16'h0000);

    // bouncing button gives no press
    for (int i = 0; i < 3; i++) begin
      sw.startStop = 1'b1;
      steps(2);
      sw.startStop = 1'b0;
      steps(2);
    end
    steps(20);
    chk("bounce_idle", {15'b0, sw.running}, 16'h0000);
    press(0, 10);
    steps(10);
    chk("bounce_then_run", {15'b0, sw.running}, 16'h0001);

    // pause with partial 0.1 s kept
    n = 0;
    while (m_frac != 3 && n < 10) begin
      step();
      n++;
    end
    sw.startStop = 1'b1;
    steps(7);
    chk("pause_stop", {15'b0, sw.running}, 16'h0000);
    saved = m_tenths;
    steps(3);
    sw.startStop = 1'b0;
    steps(37);
    chk("pause_hold", sw.value, to_bcd(saved));
    sw.startStop = 1'b1;
    steps(7);
    chk("resume_run", {15'b0, sw.running}, 16'h0001);
    steps(1);
    chk("resume_e1", sw.value, to_bcd(saved));
    steps(1);
    chk("resume_e2", sw.value, to_bcd(saved + 1));
    sw.startStop = 1'b0;
    steps(5);

    // clear ignored in RUN, honoured in STOP
    press(1, 10);
    steps(6);
    chk("clr_in_run", {15'b0, sw.running}, 16'h0001);
    press(0, 10);
    steps(3);
    press(1, 10);
    chk("clr_stop_value", sw.value, 16'h0000);
    chk("clr_stop_dots", {12'b0, sw.dots}, 16'h0002);
    press(0, 10);
    steps(20);
    press(0, 10);
    steps(5);
    sw.startStop = 1'b1;
    sw.clear = 1'b1;
    steps(10);
    sw.startStop = 1'b0;
    sw.clear = 1'b0;
    steps(5);
    chk("clr_ss_same", {15'b0, sw.running}, 16'h0000);
    chk("clr_ss_value", sw.value, 16'h0000);

    // random button activity
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw.startStop = ~sw.startStop;
      if ($urandom_range(0, 15) == 0) sw.clear = ~sw.clear;
      step();
    end
    sw.startStop = 1'b0;
    sw.clear = 1'b0;
    steps(10);
    if (m_state == 1) begin
      press(0, 10);
      steps(3);
    end
    if (m_state == 2) begin
      press(1, 10);
      steps(3);
    end
    chk("rand_idle", sw.value, 16'h0000);

    // carries and saturation
    press(0, 10);
    wait_tenths(100, 1000);
    chk("carry_0100", sw.value, 16'h0100);
    wait_tenths(1000, 5000);
    chk("carry_1000", sw.value, 16'h1000);
    n = 0;
    while (!m_ovf && n < 40000) begin
      step();
      n++;
    end
    chk("sat_bound", {15'b0, n < 40000}, 16'h0001);
    chk("sat_value", sw.value, 16'h9999);
    chk("sat_running", {15'b0, sw.running}, 16'h0000);
    chk("sat_dots", {12'b0, sw.dots}, 16'h000a);
    press(0, 10);
    steps(5);
    chk("sat_ss_ignored", {15'b0, sw.running}, 16'h0000);
    chk("sat_ss_dots", {12'b0, sw.dots}, 16'h000a);
    press(1, 10);
    steps(3);
    chk("sat_clr_value", sw.value, 16'h0000);
    chk("sat_clr_dots", {12'b0, sw.dots}, 16'h0002);

    // reset mid-run with button held through it
    press(0, 10);
    wait_tenths(345, 2000);
    chk("pre_rst_value", sw.value, 16'h0345);
    sw.startStop = 1'b1;
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    chk("mid_rst_value", sw.value, 16'h0000);
    chk("mid_rst_dots", {12'b0, sw.dots}, 16'h0002);
    chk("mid_rst_run", {15'b0, sw.running}, 16'h0000);
    steps(6);
    chk("held_c6", {15'b0, sw.running}, 16'h0000);
    steps(1);
    chk("held_c7", {15'b0, sw.running}, 16'h0001);
    sw.startStop = 1'b0;
    steps(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
